if_fetch_unit: RTL and testbench

- Instruction-fetch front end; the producer side of the IF->ID pipeline register.
- Owns the fetch PC and issues in-order requests to instruction memory over a req/gnt + rvalid interface.
- Buffers returned words and presents if_pc/if_inst/if_valid, which the IF/ID register samples every clock.
- Takes stall from the pipeline controller and branch redirects from ID, keeping the delay slot and discarding wrong-path fetches.

---
 rtl/if_fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order
// req/gnt fetches and presents if_pc/if_inst/if_valid to IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] fetch_pc;
  cnt_t        outstanding;
  cnt_t        count;
  cnt_t        drop_cnt;

  logic [31:0] tag_mem [DEPTH];
  ptr_t        tag_rd;
  ptr_t        tag_wr;

  logic [31:0] buf_pc   [DEPTH];
  logic [31:0] buf_inst [DEPTH];
  ptr_t        buf_rd;
  ptr_t        buf_wr;

  logic        redirect;
  logic [CW:0] credit;
  logic        accept;
  logic        resp;
  logic        live;
  logic [31:0] live_pc;
  logic        buf_empty;
  logic        buf_push;
  logic        buf_pop;

  logic [31:0] nxt_pc;
  logic [31:0] nxt_inst;
  logic        nxt_valid;

  assign redirect  = branch_flag && !stall;
  assign credit    = {1'b0, outstanding} + {1'b0, count};
  assign imem_req  = !rst && !redirect && (credit < CAP);
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_gnt;

  // A stray rvalid with nothing outstanding is ignored outright.
  assign resp      = imem_rvalid && (outstanding != '0);
  assign live      = resp && (drop_cnt == '0);
  assign live_pc   = tag_mem[tag_rd];
  assign buf_empty = (count == '0);

  assign buf_pop  = !rst && !redirect && !stall && !buf_empty;
  assign buf_push = !rst && !redirect && live
                 && (stall || !buf_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + cnt_t'(accept)
                   - cnt_t'(resp);
      if (redirect) begin
        fetch_pc <= branch_target_address;
        drop_cnt <= outstanding - cnt_t'(resp);
      end else begin
        if (accept)
          fetch_pc <= fetch_pc + 32'd4;
        if (resp && drop_cnt != '0)
          drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_rd <= '0;
      tag_wr <= '0;
    end else if (redirect) begin
      tag_rd <= '0;
      tag_wr <= '0;
    end else begin
      if (accept)
        tag_wr <= tag_wr + 1'b1;
      if (live)
        tag_rd <= tag_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      tag_mem[tag_wr] <= fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (buf_push) begin
      buf_pc[buf_wr]   <= live_pc;
      buf_inst[buf_wr] <= imem_rdata;
    end
  end

  // Buffered words go first; a live word bypasses only when empty.
  always_comb begin
    nxt_pc    = if_pc;
    nxt_inst  = if_inst;
    nxt_valid = if_valid;
    if (redirect) begin
      nxt_inst  = '0;
      nxt_valid = 1'b0;
    end else if (!stall) begin
      if (!buf_empty) begin
        nxt_pc    = buf_pc[buf_rd];
        nxt_inst  = buf_inst[buf_rd];
        nxt_valid = 1'b1;
      end else if (live) begin
        nxt_pc    = live_pc;
        nxt_inst  = imem_rdata;
        nxt_valid = 1'b1;
      end else begin
        nxt_inst  = '0;
        nxt_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      buf_rd   <= '0;
      buf_wr   <= '0;
      if_pc    <= '0;
      if_inst  <= '0;
      if_valid <= 1'b0;
    end else begin
      if (redirect) begin
        count  <= '0;
        buf_rd <= '0;
        buf_wr <= '0;
      end else begin
        count <= count + cnt_t'(buf_push)
               - cnt_t'(buf_pop);
        if (buf_push)
          buf_wr <= buf_wr + 1'b1;
        if (buf_pop)
          buf_rd <= buf_rd + 1'b1;
      end
      if_pc    <= nxt_pc;
      if_inst  <= nxt_inst;
      if_valid <= nxt_valid;
    end
  end

  a_no_stray_rvalid: assert property (
    @(posedge clk) disable iff (rst)
    imem_rvalid |-> (outstanding != '0));

  a_credit: assert property (
    @(posedge clk) disable iff (rst)
    credit <= CAP);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory model plus a queue-level
// reference of the fetch stream, directed then random phases.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC(RESET_PC),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .branch_flag(branch_flag),
    .branch_target_address(branch_target_address),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .if_pc(if_pc),
    .if_inst(if_inst),
    .if_valid(if_valid)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          doomed;
  } ent_t;

  // mq: requests accepted by memory, not yet answered.
  // ready_q: fetched right-path PCs not yet presented.
  ent_t        mq[$];
  logic [31:0] ready_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] m_pc;
  logic [31:0] e_pc;
  logic [31:0] e_inst;
  logic        e_valid;
  bit          armed = 1'b0;

  int gnt_every = 1;
  int lat_min = 1;
  int lat_max = 1;
  bit hold_rv = 1'b0;
  bit rv_rand = 1'b0;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        req_s;
    logic [31:0] addr_s;
    bit          redirect;
    bit          exp_req;
    ent_t        e;
    if (gnt_every == 0)
      imem_gnt = 1'($urandom_range(0, 1));
    else
      imem_gnt = ((cyc % gnt_every) == 0);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (!rst && !hold_rv && mq.size() > 0
        && mq[0].due <= cyc
        && (!rv_rand || $urandom_range(0, 3) != 0)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(mq[0].addr);
    end
    #1;
    req_s    = imem_req;
    addr_s   = imem_addr;
    redirect = !rst && branch_flag && !stall;
    exp_req  = !rst && !redirect
            && (mq.size() + ready_q.size() < DEPTH);
    check("imem_req", 32'(req_s), 32'(exp_req));
    if (exp_req)
      check("imem_addr", addr_s, m_pc);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      ready_q.delete();
      m_pc    = RESET_PC;
      e_pc    = '0;
      e_inst  = '0;
      e_valid = 1'b0;
      armed   = 1'b1;
    end else begin
      if (imem_rvalid) begin
        e = mq.pop_front();
        if (!e.doomed && !redirect)
          ready_q.push_back(e.addr);
      end
      if (req_s && imem_gnt) begin
        mq.push_back('{m_pc,
          cyc + int'($urandom_range(lat_min, lat_max)),
          1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (redirect) begin
        ready_q.delete();
        foreach (mq[i]) mq[i].doomed = 1'b1;
        m_pc    = branch_target_address;
        e_inst  = '0;
        e_valid = 1'b0;
      end else if (!stall) begin
        if (ready_q.size() > 0) begin
          e_pc    = ready_q.pop_front();
          e_inst  = word_of(e_pc);
          e_valid = 1'b1;
        end else begin
          e_inst  = '0;
          e_valid = 1'b0;
        end
      end
    end
    cyc++;
    @(negedge clk);
    if (armed) begin
      check("if_valid", 32'(if_valid), 32'(e_valid));
      check("if_pc", if_pc, e_pc);
      check("if_inst", if_inst, e_inst);
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    stall = 1'b0;
    branch_flag = 1'b0;
    branch_target_address = '0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;

    repeat (2) tick();
    rst = 1'b0;

    // 1-cycle memory streaming
    repeat (8) tick();

    // stall mid-stream
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    repeat (4) tick();

    // reset with two requests in flight
    hold_rv = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    hold_rv = 1'b0;
    rst = 1'b0;

    // branch while pc=8 is presented
    lat_min = 2;
    lat_max = 2;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      tick();
      found = e_valid && (e_pc == 32'h8);
    end
    check("wait_pc8", 32'(found), 32'd1);
    branch_flag = 1'b1;
    branch_target_address = 32'h100;
    tick();
    branch_flag = 1'b0;
    repeat (8) tick();

    // slow memory
    gnt_every = 3;
    repeat (20) tick();

    // rvalid withheld
    gnt_every = 1;
    lat_min = 1;
    lat_max = 1;
    hold_rv = 1'b1;
    repeat (5) tick();
    hold_rv = 1'b0;
    repeat (6) tick();

    // PC wrap around 2^32
    branch_flag = 1'b1;
    branch_target_address = 32'hFFFF_FFF8;
    tick();
    branch_flag = 1'b0;
    repeat (8) tick();

    // random traffic
    gnt_every = 0;
    lat_min = 1;
    lat_max = 3;
    rv_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      branch_flag = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0)
        branch_target_address = 32'hFFFF_FFF0;
      else
        branch_target_address = $urandom & 32'hFFFF_FFFC;
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    stall = 1'b0;
    branch_flag = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
